// File: rtl/vend_pkg.sv
// Shared types for the vending session controller: coin codes, FSM states, coin helpers.
package vend_pkg;

  typedef enum logic [2:0] {
    CoinNone     = 3'd0,
    CoinCircle   = 3'd1,
    CoinTriangle = 3'd2,
    CoinPentagon = 3'd3
  } coin_t;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StEval,
    StDisp1,
    StDisp2,
    StDone
  } state_t;

  localparam logic [1:0] MaxCount = 2'd3;
  localparam logic [4:0] MaxPaid  = 5'd15;

  function automatic logic [3:0] coin_value(input logic [2:0] code);
    case (code)
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic coin_legal(input logic [2:0] code);
    return (code == 3'd1) || (code == 3'd2) || (code == 3'd3);
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Coin inventory: three 2-bit saturating counters, increment/decrement selected by coin code.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int unsigned INIT_PENT = 2,
  parameter int unsigned INIT_TRI  = 2,
  parameter int unsigned INIT_CIR  = 2
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       inc,
  input  logic [2:0] inc_coin,
  input  logic       dec,
  input  logic [2:0] dec_coin,
  output logic [1:0] pentagons,
  output logic [1:0] triangles,
  output logic [1:0] circles
);

  function automatic logic [1:0] next_count(input logic [1:0] cnt, input logic up,
                                            input logic dn);
    if (up && cnt != MaxCount) return cnt + 2'd1;
    if (dn && cnt != 2'd0) return cnt - 2'd1;
    return cnt;
  endfunction

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pentagons <= 2'(INIT_PENT);
      triangles <= 2'(INIT_TRI);
      circles   <= 2'(INIT_CIR);
    end else begin
      pentagons <= next_count(pentagons, inc && (inc_coin == CoinPentagon),
                              dec && (dec_coin == CoinPentagon));
      triangles <= next_count(triangles, inc && (inc_coin == CoinTriangle),
                              dec && (dec_coin == CoinTriangle));
      circles   <= next_count(circles, inc && (inc_coin == CoinCircle),
                              dec && (dec_coin == CoinCircle));
    end
  end

endmodule

// File: rtl/vend_session_controller.sv
// Vending session FSM around the change-maker datapath: coin collection, evaluation, dispensing.
// Optional idle timeout in COLLECT is enabled with `define VEND_TIMEOUT_EN.
module vend_session_controller
  import vend_pkg::*;
#(
  parameter int unsigned INIT_PENT      = 2,
  parameter int unsigned INIT_TRI       = 2,
  parameter int unsigned INIT_CIR       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic [3:0] Cost,
  input  logic       coin_valid,
  input  logic [2:0] coin_type,
  output logic       coin_ready,
  output logic       coin_reject,
  input  logic       pay_done,
  output logic [3:0] Paid,
  output logic [3:0] CostQ,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  input  logic [2:0] FirstCoin,
  input  logic [2:0] SecondCoin,
  input  logic       ExactAmount,
  input  logic       NotEnoughChange,
  input  logic       CoughUpMore,
  output logic       disp_valid,
  output logic [2:0] disp_coin,
  input  logic       disp_ready,
  output logic       vend,
  output logic       no_change,
  output logic       busy
);

  state_t     state;
  logic [2:0] second_q;
  logic       coin_hs;
  logic       coin_ok;
  logic       reject;
  logic       accept;
  logic       disp_hs;
  logic       timeout_hit;
  logic [4:0] paid_sum;
  logic [1:0] sel_count;

  assign coin_hs  = coin_ready && coin_valid;
  assign coin_ok  = coin_legal(coin_type);
  assign paid_sum = {1'b0, Paid} + {1'b0, coin_value(coin_type)};

  always_comb begin
    sel_count = 2'd0;
    case (coin_type)
      CoinCircle:   sel_count = Circles;
      CoinTriangle: sel_count = Triangles;
      CoinPentagon: sel_count = Pentagons;
      default:      sel_count = 2'd0;
    endcase
  end

  assign reject  = coin_ok && ((paid_sum > MaxPaid) || (sel_count == MaxCount));
  assign accept  = coin_hs && coin_ok && !reject;
  assign disp_hs = disp_valid && disp_ready;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TimeoutW-1:0] idle_cnt;

  // Cleared outside COLLECT so every entry into COLLECT starts a fresh idle window.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      idle_cnt <= '0;
    end else if (state != StCollect || coin_hs) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == StCollect) && !coin_hs &&
                       (idle_cnt == TimeoutW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  coin_inventory #(
    .INIT_PENT(INIT_PENT),
    .INIT_TRI (INIT_TRI),
    .INIT_CIR (INIT_CIR)
  ) u_inventory (
    .clock    (clock),
    .reset_L  (reset_L),
    .inc      (accept),
    .inc_coin (coin_type),
    .dec      (disp_hs),
    .dec_coin (disp_coin),
    .pentagons(Pentagons),
    .triangles(Triangles),
    .circles  (Circles)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= StIdle;
      Paid        <= 4'd0;
      CostQ       <= 4'd0;
      second_q    <= CoinNone;
      coin_ready  <= 1'b0;
      coin_reject <= 1'b0;
      disp_valid  <= 1'b0;
      disp_coin   <= CoinNone;
      vend        <= 1'b0;
      no_change   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      vend        <= 1'b0;
      no_change   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            CostQ      <= Cost;
            Paid       <= 4'd0;
            coin_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= StCollect;
          end
        end
        StCollect: begin
          if (coin_hs && coin_ok) begin
            if (reject) coin_reject <= 1'b1;
            else        Paid        <= paid_sum[3:0];
          end
          // The coin on a pay_done cycle is counted first; EVAL sees the updated Paid.
          if (pay_done) begin
            coin_ready <= 1'b0;
            state      <= StEval;
          end else if (timeout_hit) begin
            coin_ready <= 1'b0;
            no_change  <= 1'b1;
            state      <= StDone;
          end
        end
        StEval: begin
          if (CoughUpMore) begin
            coin_ready <= 1'b1;
            state      <= StCollect;
          end else if (NotEnoughChange) begin
            no_change <= 1'b1;
            state     <= StDone;
          end else if (ExactAmount || (FirstCoin == CoinNone && SecondCoin == CoinNone)) begin
            vend  <= 1'b1;
            state <= StDone;
          end else begin
            second_q   <= SecondCoin;
            disp_valid <= 1'b1;
            if (FirstCoin != CoinNone) begin
              disp_coin <= FirstCoin;
              state     <= StDisp1;
            end else begin
              disp_coin <= SecondCoin;
              state     <= StDisp2;
            end
          end
        end
        StDisp1: begin
          if (disp_ready) begin
            if (second_q != CoinNone) begin
              disp_coin <= second_q;
              state     <= StDisp2;
            end else begin
              disp_valid <= 1'b0;
              disp_coin  <= CoinNone;
              vend       <= 1'b1;
              state      <= StDone;
            end
          end
        end
        StDisp2: begin
          if (disp_ready) begin
            disp_valid <= 1'b0;
            disp_coin  <= CoinNone;
            vend       <= 1'b1;
            state      <= StDone;
          end
        end
        StDone: begin
          Paid  <= 4'd0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
